// File: rtl/odd_parity_checker.sv
//----------------------------------------------------------------------------
// OddParityChecker
//
// Receive-side stage for the serial odd-parity path. Incoming frames are
// DATA_W data bits sent LSB first, followed by one odd-parity bit. The stage
// reassembles each data word and checks that the total number of ones over
// data plus parity is odd. It then presents the word for one cycle with an
// error flag. A saturating counter records how many frames failed the check.
//
// Parameters:
//   DATA_W      data bits per frame (must be >= 1)
//   CNT_W       width of the parity-error counter
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   reset       synchronous, active-high reset
//   in_bit      serial data / parity bit
//   in_valid    in_bit is consumed on any edge where this is high
//   flush       abandons the partial frame and returns to bit 0
//   err_clr     clears the sticky error flag (sticky build only)
//   data_out    reassembled data word, held until the next frame completes
//   out_valid   one-cycle pulse per completed frame
//   parity_err  parity failure of the frame currently presented
//   err_count   saturating count of failed frames
//   err_sticky  sticky error indicator (tied low unless the macro is set)
//   bit_idx     current position within the frame, for debug
//
// Build option:
//   ODD_PARITY_CHECKER_STICKY_ERR_EN  enables the sticky error flag. When it
//   is undefined, err_sticky reads 0 and err_clr is ignored.
//----------------------------------------------------------------------------
module odd_parity_checker #(
    parameter int DATA_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_bit,
    input  logic                         in_valid,
    input  logic                         flush,
    input  logic                         err_clr,
    output logic [DATA_W-1:0]            data_out,
    output logic                         out_valid,
    output logic                         parity_err,
    output logic [CNT_W-1:0]             err_count,
    output logic                         err_sticky,
    output logic [$clog2(DATA_W+1)-1:0]  bit_idx
);

    localparam int IDX_W = $clog2(DATA_W + 1);

    // Frame position of the last data bit. Accepting this bit moves the
    // checker into the parity phase.
    localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] PAR_IDX       = IDX_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX       = '1;

    // Two-phase frame walker: collecting data bits, then expecting parity.
    localparam logic ST_DATA = 1'b0;
    localparam logic ST_PAR  = 1'b1;

    logic                state_q,      state_d;
    logic [IDX_W-1:0]    bitIdx_q,     bitIdx_d;
    logic [DATA_W-1:0]   shiftReg_q,   shiftReg_d;
    logic [DATA_W-1:0]   dataOut_q,    dataOut_d;
    logic                outValid_q,   outValid_d;
    logic                parityErr_q,  parityErr_d;
    logic [CNT_W-1:0]    errCount_q,   errCount_d;

    logic                frameDone;
    logic                frameBad;

    // A frame completes only when the parity bit is actually taken. Flush
    // wins over in_valid, so a parity bit presented together with flush is
    // dropped and no result is produced. Odd parity holds when the XOR over
    // data and parity is 1, so a zero XOR marks a failed frame.
    always_comb begin
        frameDone = 1'b0;
        frameBad  = 1'b0;
        if (!flush && in_valid && (state_q == ST_PAR)) begin
            frameDone = 1'b1;
            frameBad  = ~((^shiftReg_q) ^ in_bit);
        end
    end

    // Next-state logic for the frame walker and the presented result.
    // out_valid defaults low so it can only ever be a single-cycle pulse.
    // data_out and parity_err hold their values between frames.
    always_comb begin
        state_d     = state_q;
        bitIdx_d    = bitIdx_q;
        shiftReg_d  = shiftReg_q;
        dataOut_d   = dataOut_q;
        outValid_d  = 1'b0;
        parityErr_d = parityErr_q;

        if (flush) begin
            state_d    = ST_DATA;
            bitIdx_d   = '0;
            shiftReg_d = '0;
        end else if (in_valid) begin
            case (state_q)
                ST_DATA: begin
                    // The first received bit lands in bit 0 of the word.
                    for (int i = 0; i < DATA_W; i++) begin
                        if (bitIdx_q == IDX_W'(i)) begin
                            shiftReg_d[i] = in_bit;
                        end
                    end
                    if (bitIdx_q == LAST_DATA_IDX) begin
                        state_d  = ST_PAR;
                        bitIdx_d = PAR_IDX;
                    end else begin
                        bitIdx_d = bitIdx_q + 1'b1;
                    end
                end
                ST_PAR: begin
                    dataOut_d   = shiftReg_q;
                    outValid_d  = 1'b1;
                    parityErr_d = frameBad;
                    state_d     = ST_DATA;
                    bitIdx_d    = '0;
                    shiftReg_d  = '0;
                end
                default: begin
                    state_d    = ST_DATA;
                    bitIdx_d   = '0;
                    shiftReg_d = '0;
                end
            endcase
        end
    end

    // The error counter steps on the same edge that raises parity_err. It
    // stops at all-ones so that a long burst of failures cannot wrap back
    // to a small value.
    always_comb begin
        errCount_d = errCount_q;
        if (frameBad && (errCount_q != CNT_MAX)) begin
            errCount_d = errCount_q + 1'b1;
        end
    end

    // State registers. Reset discards any partial frame and clears every
    // output. No out_valid is generated for the abandoned frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_DATA;
            bitIdx_q    <= '0;
            shiftReg_q  <= '0;
            dataOut_q   <= '0;
            outValid_q  <= 1'b0;
            parityErr_q <= 1'b0;
            errCount_q  <= '0;
        end else begin
            state_q     <= state_d;
            bitIdx_q    <= bitIdx_d;
            shiftReg_q  <= shiftReg_d;
            dataOut_q   <= dataOut_d;
            outValid_q  <= outValid_d;
            parityErr_q <= parityErr_d;
            errCount_q  <= errCount_d;
        end
    end

`ifdef ODD_PARITY_CHECKER_STICKY_ERR_EN
    logic sticky_q, sticky_d;

    // Sticky flag: a failing frame sets it and err_clr clears it. When both
    // happen on the same edge, the set is applied last and wins, so a
    // failure that coincides with the clear is still reported.
    always_comb begin
        sticky_d = sticky_q;
        if (err_clr) begin
            sticky_d = 1'b0;
        end
        if (frameBad) begin
            sticky_d = 1'b1;
        end
    end

    // Sticky flag register, cleared by reset like all other state.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign err_sticky = sticky_q;
`else
    // Without the sticky feature err_clr has nothing to act on.
    logic unusedErrClr;
    assign unusedErrClr = err_clr;
    assign err_sticky   = 1'b0;
`endif

    assign data_out   = dataOut_q;
    assign out_valid  = outValid_q;
    assign parity_err = parityErr_q;
    assign err_count  = errCount_q;
    assign bit_idx    = bitIdx_q;

endmodule

// File: tb/tb_odd_parity_checker.sv
//----------------------------------------------------------------------------
// tb_odd_parity_checker
//
// Self-checking bench for odd_parity_checker. It drives two instances from
// the same stimulus:
//   - one instance with the default counter width
//   - one instance with a 2-bit counter, so that saturation is reachable
//
// The reference model works on frames, not on registers. It collects the
// accepted bits in a queue. Once DATA_W+1 bits are queued, it builds the word
// from the data bits and counts the ones to decide whether parity held.
// Directed scenarios compare against literal expected values. The random
// scenario compares against the model on every cycle.
//----------------------------------------------------------------------------
module tb_odd_parity_checker;

    localparam int DATA_W = 3;
    localparam int CNT_W  = 8;
    localparam int CNT_W2 = 2;
    localparam int IDX_W  = $clog2(DATA_W + 1);

`ifdef ODD_PARITY_CHECKER_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_bit = 1'b0;
    logic in_valid = 1'b0;
    logic flush = 1'b0;
    logic err_clr = 1'b0;

    logic [DATA_W-1:0] data_out,   data_out2;
    logic              out_valid,  out_valid2;
    logic              parity_err, parity_err2;
    logic [CNT_W-1:0]  err_count;
    logic [CNT_W2-1:0] err_count2;
    logic              err_sticky, err_sticky2;
    logic [IDX_W-1:0]  bit_idx,    bit_idx2;

    int checks = 0;
    int errors = 0;

    // Frame-level reference model state.
    bit                mBits[$];
    logic [DATA_W-1:0] mData;
    logic              mValid;
    logic              mErr;
    logic              mSticky;
    int                mCnt;
    int                mCnt2;

    always #5 clk = ~clk;

    odd_parity_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid),
        .flush(flush), .err_clr(err_clr), .data_out(data_out),
        .out_valid(out_valid), .parity_err(parity_err),
        .err_count(err_count), .err_sticky(err_sticky), .bit_idx(bit_idx)
    );

    odd_parity_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W2)) dut2 (
        .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid),
        .flush(flush), .err_clr(err_clr), .data_out(data_out2),
        .out_valid(out_valid2), .parity_err(parity_err2),
        .err_count(err_count2), .err_sticky(err_sticky2), .bit_idx(bit_idx2)
    );

    // Drive one cycle of inputs, let the edge happen, and advance the model.
    // Outputs are sampled 1 time unit after the edge.
    task automatic applyStimulus(input logic v, input logic b, input logic f, input logic c);
        int ones;
        bit failed;
        in_valid = v;
        in_bit   = b;
        flush    = f;
        err_clr  = c;
        @(posedge clk);
        failed = 1'b0;
        mValid = 1'b0;
        if (f) begin
            mBits.delete();
        end else if (v) begin
            mBits.push_back(b);
            if (mBits.size() == DATA_W + 1) begin
                ones  = 0;
                mData = '0;
                for (int i = 0; i <= DATA_W; i++) begin
                    ones += int'(mBits[i]);
                    if (i < DATA_W) mData[i] = mBits[i];
                end
                mErr   = ((ones % 2) == 0);
                mValid = 1'b1;
                failed = mErr;
                if (failed && mCnt  < (1 << CNT_W)  - 1) mCnt++;
                if (failed && mCnt2 < (1 << CNT_W2) - 1) mCnt2++;
                mBits.delete();
            end
        end
        if (STICKY) begin
            if (c) mSticky = 1'b0;
            if (failed) mSticky = 1'b1;
        end
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        err_clr  = 1'b0;
    endtask

    // Reset is applied with a live bit on in_valid, so that reset priority
    // over normal input consumption is exercised as well.
    task automatic applyReset();
        reset    = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        @(posedge clk);
        mBits.delete();
        mData   = '0;
        mValid  = 1'b0;
        mErr    = 1'b0;
        mSticky = 1'b0;
        mCnt    = 0;
        mCnt2   = 0;
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic test_reset();
        applyReset();
        checks++; if (data_out !== 3'b000) begin errors++; $display("[TB] FAIL reset_data: got %b expected 000", data_out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_perr: got %b expected 0", parity_err); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", err_count); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("[TB] FAIL reset_sticky: got %b expected 0", err_sticky); end
        checks++; if (bit_idx !== 2'd0) begin errors++; $display("[TB] FAIL reset_idx: got %0d expected 0", bit_idx); end
    endtask

    task automatic test_basic();
        bit seq[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, seq[i], 1'b0, 1'b0);
            if (i < 3) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_valid[%0d]: got %b expected 0", i, out_valid); end
                checks++; if (bit_idx !== IDX_W'(i + 1)) begin errors++; $display("[TB] FAIL basic_idx[%0d]: got %0d expected %0d", i, bit_idx, i + 1); end
            end
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: got %b expected 1", out_valid); end
        checks++; if (data_out !== 3'b101) begin errors++; $display("[TB] FAIL basic_data: got %b expected 101", data_out); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("[TB] FAIL basic_perr: got %b expected 0", parity_err); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("[TB] FAIL basic_cnt: got %0d expected 0", err_count); end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_pulse_width: got %b expected 0", out_valid); end
        checks++; if (data_out !== 3'b101) begin errors++; $display("[TB] FAIL basic_hold: got %b expected 101", data_out); end
    endtask

    task automatic test_bad_frame();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bad_valid: got %b expected 1", out_valid); end
        checks++; if (data_out !== 3'b000) begin errors++; $display("[TB] FAIL bad_data: got %b expected 000", data_out); end
        checks++; if (parity_err !== 1'b1) begin errors++; $display("[TB] FAIL bad_perr: got %b expected 1", parity_err); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("[TB] FAIL bad_cnt: got %0d expected 1", err_count); end
        checks++; if (err_sticky !== STICKY) begin errors++; $display("[TB] FAIL bad_sticky: got %b expected %b", err_sticky, STICKY); end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (err_sticky !== STICKY) begin errors++; $display("[TB] FAIL bad_sticky_hold: got %b expected %b", err_sticky, STICKY); end
        checks++; if (parity_err !== 1'b1) begin errors++; $display("[TB] FAIL bad_perr_hold: got %b expected 1", parity_err); end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("[TB] FAIL bad_sticky_clr: got %b expected 0", err_sticky); end
        // A failing frame that completes together with err_clr keeps the flag set.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checks++; if (err_sticky !== STICKY) begin errors++; $display("[TB] FAIL bad_set_wins: got %b expected %b", err_sticky, STICKY); end
        checks++; if (err_count !== 8'd2) begin errors++; $display("[TB] FAIL bad_cnt2: got %0d expected 2", err_count); end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("[TB] FAIL bad_sticky_clr2: got %b expected 0", err_sticky); end
    endtask

    task automatic test_back_to_back();
        bit seq[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        int pulseAt[$];
        logic [DATA_W-1:0] gotData[$];
        logic gotErr[$];
        applyReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, seq[i], 1'b0, 1'b0);
            if (out_valid === 1'b1) begin
                pulseAt.push_back(i);
                gotData.push_back(data_out);
                gotErr.push_back(parity_err);
            end
        end
        checks++;
        if (pulseAt.size() != 2) begin
            errors++; $display("[TB] FAIL b2b_pulses: got %0d expected 2", pulseAt.size());
        end else begin
            checks++; if (pulseAt[0] != 3 || pulseAt[1] != 7) begin errors++; $display("[TB] FAIL b2b_timing: got %0d,%0d expected 3,7", pulseAt[0], pulseAt[1]); end
            checks++; if (gotData[0] !== 3'b011 || gotErr[0] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_frame0: got %b/%b expected 011/0", gotData[0], gotErr[0]); end
            checks++; if (gotData[1] !== 3'b010 || gotErr[1] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_frame1: got %b/%b expected 010/0", gotData[1], gotErr[1]); end
        end
    endtask

    task automatic test_gap();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            checks++; if (bit_idx !== 2'd1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL gap_hold[%0d]: got idx %0d valid %b expected 1/0", i, bit_idx, out_valid); end
        end
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL gap_valid: got %b expected 1", out_valid); end
        checks++; if (data_out !== 3'b001 || parity_err !== 1'b0) begin errors++; $display("[TB] FAIL gap_result: got %b/%b expected 001/0", data_out, parity_err); end
    endtask

    task automatic test_flush();
        bit seq[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        int pulses = 0;
        applyReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checks++; if (bit_idx !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_idx: got idx %0d valid %b expected 0/0", bit_idx, out_valid); end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, seq[i], 1'b0, 1'b0);
            if (out_valid === 1'b1) pulses++;
        end
        checks++; if (pulses != 1) begin errors++; $display("[TB] FAIL flush_pulses: got %0d expected 1", pulses); end
        checks++; if (data_out !== 3'b111 || parity_err !== 1'b0) begin errors++; $display("[TB] FAIL flush_result: got %b/%b expected 111/0", data_out, parity_err); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("[TB] FAIL flush_cnt: got %0d expected 0", err_count); end
        // Flush in the same cycle as the parity bit: no result is produced.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0 || bit_idx !== 2'd0) begin errors++; $display("[TB] FAIL flush_par: got valid %b idx %0d expected 0/0", out_valid, bit_idx); end
        checks++; if (data_out !== 3'b111 || err_count !== 8'd0) begin errors++; $display("[TB] FAIL flush_par_hold: got %b cnt %0d expected 111 cnt 0", data_out, err_count); end
    endtask

    task automatic test_saturation();
        int expSat[5] = '{1, 2, 3, 3, 3};
        applyReset();
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            checks++; if (int'(err_count2) != expSat[f]) begin errors++; $display("[TB] FAIL sat_cnt2[%0d]: got %0d expected %0d", f, err_count2, expSat[f]); end
            checks++; if (int'(err_count) != f + 1) begin errors++; $display("[TB] FAIL sat_cnt[%0d]: got %0d expected %0d", f, err_count, f + 1); end
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyReset();
        checks++; if (out_valid !== 1'b0 || data_out !== 3'b000 || parity_err !== 1'b0) begin errors++; $display("[TB] FAIL midreset_out: got v%b d%b e%b expected 0/000/0", out_valid, data_out, parity_err); end
        checks++; if (err_count !== 8'd0 || err_count2 !== 2'd0 || bit_idx !== 2'd0 || err_sticky !== 1'b0) begin errors++; $display("[TB] FAIL midreset_state: got cnt %0d cnt2 %0d idx %0d sticky %b expected all 0", err_count, err_count2, bit_idx, err_sticky); end
    endtask

    task automatic test_random();
        logic v, b, f, c;
        applyReset();
        for (int n = 0; n < 600; n++) begin
            v = ($urandom_range(3) != 0);
            b = 1'($urandom_range(1));
            f = ($urandom_range(15) == 0);
            c = ($urandom_range(7) == 0);
            applyStimulus(v, b, f, c);
            checks++; if (out_valid !== mValid) begin errors++; $display("[TB] FAIL rnd_valid@%0d: got %b expected %b", n, out_valid, mValid); end
            checks++; if (bit_idx !== IDX_W'(mBits.size())) begin errors++; $display("[TB] FAIL rnd_idx@%0d: got %0d expected %0d", n, bit_idx, mBits.size()); end
            checks++; if (data_out !== mData || parity_err !== mErr) begin errors++; $display("[TB] FAIL rnd_result@%0d: got %b/%b expected %b/%b", n, data_out, parity_err, mData, mErr); end
            checks++; if (int'(err_count) != mCnt || int'(err_count2) != mCnt2) begin errors++; $display("[TB] FAIL rnd_cnt@%0d: got %0d/%0d expected %0d/%0d", n, err_count, err_count2, mCnt, mCnt2); end
            checks++; if (err_sticky !== mSticky) begin errors++; $display("[TB] FAIL rnd_sticky@%0d: got %b expected %b", n, err_sticky, mSticky); end
        end
    endtask

    initial begin
        $display("[TB] odd_parity_checker bench start (sticky=%0d)", STICKY);
        test_reset();
        test_basic();
        test_bad_frame();
        test_back_to_back();
        test_gap();
        test_flush();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/odd_parity_checker.md
Name: odd_parity_checker

Overview:
- Receive-side stage for the serial odd-parity generator path; sits directly downstream of it.
- Consumes a serial stream of frames. Each frame is DATA_W data bits, LSB first, followed by one odd-parity bit.
- Reassembles each data word, checks odd parity over data plus parity bit, and presents the word with an error flag.
- Keeps a saturating count of parity failures for status readback.

Parameters:
- DATA_W, 3, data bits per frame; must be >= 1.
- CNT_W, 8, width of the parity-error counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_bit  in  1  serial data/parity bit.
- in_valid  in  1  in_bit is consumed on any rising edge where in_valid=1; gaps of any length are allowed.
- flush  in  1  abandons the partial frame and returns to bit 0.
- err_clr  in  1  clears the sticky error flag; only has an effect with STICKY_ERR_EN.
- data_out  out  DATA_W  reassembled data word.
- out_valid  out  1  one-cycle pulse; data_out and parity_err are valid while it is high.
- parity_err  out  1  parity failure for the frame currently presented.
- err_count  out  CNT_W  saturating count of failed frames.
- err_sticky  out  1  sticky error indicator (see Optional Feature).
- bit_idx  out  clog2(DATA_W+1)  current position in frame, for debug.

Behaviour:
- Reset: clk is the clock; reset is synchronous, active-high. All outputs and internal registers go to 0 (data_out, out_valid, parity_err, err_count, err_sticky, bit_idx, shift register, state = DATA).
- States:
  - DATA: collecting data bits. bit_idx runs 0..DATA_W-1.
  - PAR: waiting for the parity bit. bit_idx = DATA_W.
- DATA state: on in_valid=1, shift_reg[bit_idx] <= in_bit (first-received bit is data_out[0]). bit_idx increments. When bit DATA_W-1 is accepted, go to PAR.
- PAR state, on in_valid=1 (parity bit accepted on edge N):
  - Edge N: data_out <= shift_reg; out_valid <= 1; parity_err <= ~(^shift_reg ^ in_bit); state -> DATA; bit_idx -> 0.
  - Latency is one edge: outputs are visible in the cycle after edge N.
  - Odd-parity rule: the total count of ones over data plus parity must be odd. Example: data 000 requires parity 1.
- out_valid is high for exactly one cycle per completed frame. data_out and parity_err hold their values until the next frame completes.
- Back-to-back frames with no idle cycles are supported. The first data bit of the next frame may arrive in the cycle where out_valid is high.
- err_count increments on the same edge that sets parity_err=1. It saturates at 2^CNT_W-1 and never wraps.
- in_valid=0: no state change. out_valid drops to 0.
- flush=1:
  - On the next edge, state -> DATA, bit_idx -> 0, shift register cleared.
  - An in_bit presented in the same cycle is dropped.
  - out_valid is 0 on that edge, even if the flushed bit would have been the parity bit.
  - err_count, data_out and parity_err are unchanged.
- reset has priority over flush, and flush has priority over in_valid.
- Reset mid-frame discards the partial frame; no out_valid is generated.

Optional Feature:
- Macro: ODD_PARITY_CHECKER_STICKY_ERR_EN.
- Defined:
  - err_sticky is set on any edge where a frame completes with parity failure. It stays set until err_clr=1.
  - err_clr clears it on the next edge.
  - If a failing frame completes in the same cycle as err_clr, the set wins and err_sticky stays 1.
- Undefined:
  - err_sticky is tied to 0 and err_clr is ignored.
  - All other behaviour is identical.

Test Plan:
- Reset then stream bits 1,0,1,1 with in_valid=1 continuously -> one cycle after the 4th bit: data_out=3'b101, out_valid=1, parity_err=0, err_count=0.
- Frame 0,0,0,0 -> data_out=3'b000, parity_err=1, err_count=1; with the macro defined, err_sticky=1 until err_clr is pulsed.
- Two back-to-back frames (1,1,0,1 then 0,1,0,0) -> out_valid pulses on two edges exactly 4 cycles apart. Outputs are 3'b011/err=0, then 3'b010/err=0.
- Bits 1,(in_valid=0 for 3 cycles),0,0,0 -> data_out=3'b001, parity_err=0; gap cycles produce no state change.
- Bits 1,0 then flush, then 1,1,1,0 -> only one out_valid pulse: data_out=3'b111, parity_err=0; err_count unchanged.
- CNT_W=2, send 5 bad frames -> err_count reads 1,2,3,3,3 (saturates); assert reset during a partial frame -> all outputs 0, no out_valid.
